// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: HI/LO op codes and the mul/div FSM states.
package mips_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MFHI  = 4'd7,
    MD_MFLO  = 4'd8
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } md_state_e;

endpackage

// File: rtl/ex_muldiv.sv
// EX-stage multi-cycle multiply/divide unit owning the HI/LO registers.
// Radix-2 shift-add multiply and restoring divide on magnitudes, sign-fixed at FINISH.
module ex_muldiv
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             md_valid_i,
  input  logic [3:0]       md_op_i,
  input  logic [WIDTH-1:0] rs_i,
  input  logic [WIDTH-1:0] rt_i,
  input  logic             abort_i,
  output logic             busy_o,
  output logic             stall_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic [WIDTH-1:0] mf_data_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  function automatic logic [WIDTH-1:0] cond_neg(input logic neg, input logic [WIDTH-1:0] v);
    if (neg) begin
      return -v;
    end else begin
      return v;
    end
  endfunction

  md_state_e          state_r, state_s;
  logic [CW-1:0]      cnt_r;
  logic [2*WIDTH-1:0] acc_r;
  logic [WIDTH-1:0]   b_r;
  logic [WIDTH-1:0]   hi_r, lo_r;
  logic               is_div_r, res_neg_r, rem_neg_r, div0_r;

  logic               start_s, signed_s, is_div_s, mt_hi_s, mt_lo_s;
  logic               a_neg_s, b_neg_s;
  logic [WIDTH-1:0]   a_mag_s, b_mag_s;
  logic [WIDTH:0]     mul_sum_s, div_trial_s, div_diff_s;
  logic [2*WIDTH-1:0] mul_next_s, div_next_s, prod_fix_s;
  logic [WIDTH-1:0]   fin_hi_s, fin_lo_s;
  logic               wr_fin_s, busy_s;

  // Request decode: only an unaborted request in IDLE has any effect
  always_comb begin
    start_s  = 1'b0;
    signed_s = 1'b0;
    is_div_s = 1'b0;
    mt_hi_s  = 1'b0;
    mt_lo_s  = 1'b0;
    if (md_valid_i && !abort_i && (state_r == IDLE)) begin
      case (md_op_e'(md_op_i))
        MD_MULT:  begin start_s = 1'b1; signed_s = 1'b1; end
        MD_MULTU: begin start_s = 1'b1; end
        MD_DIV:   begin start_s = 1'b1; signed_s = 1'b1; is_div_s = 1'b1; end
        MD_DIVU:  begin start_s = 1'b1; is_div_s = 1'b1; end
        MD_MTHI:  begin mt_hi_s = 1'b1; end
        MD_MTLO:  begin mt_lo_s = 1'b1; end
        default:  begin start_s = 1'b0; end
      endcase
    end else begin
      start_s = 1'b0;
    end
  end

  assign a_neg_s = signed_s & rs_i[WIDTH-1];
  assign b_neg_s = signed_s & rt_i[WIDTH-1];
  assign a_mag_s = cond_neg(a_neg_s, rs_i);
  assign b_mag_s = cond_neg(b_neg_s, rt_i);

  // One iteration step; the low half of acc_r holds the multiplier or the dividend bits
  always_comb begin
    mul_sum_s   = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, (acc_r[0] ? b_r : {WIDTH{1'b0}})};
    mul_next_s  = {mul_sum_s, acc_r[WIDTH-1:1]};
    div_trial_s = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
    div_diff_s  = div_trial_s - {1'b0, b_r};
    if (div_diff_s[WIDTH]) begin
      div_next_s = {div_trial_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
    end else begin
      div_next_s = {div_diff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
    end
  end

  assign prod_fix_s = res_neg_r ? -acc_r : acc_r;

  // Sign correction; divide-by-zero leaves the dividend in the remainder, so HI becomes rs raw
  always_comb begin
    fin_hi_s = prod_fix_s[2*WIDTH-1:WIDTH];
    fin_lo_s = prod_fix_s[WIDTH-1:0];
    if (is_div_r) begin
      fin_hi_s = cond_neg(rem_neg_r, acc_r[2*WIDTH-1:WIDTH]);
      fin_lo_s = div0_r ? {WIDTH{1'b1}} : cond_neg(res_neg_r, acc_r[WIDTH-1:0]);
    end else begin
      fin_hi_s = prod_fix_s[2*WIDTH-1:WIDTH];
      fin_lo_s = prod_fix_s[WIDTH-1:0];
    end
  end

  assign wr_fin_s = (state_r == FINISH) & ~abort_i;

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_s) begin
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (abort_i) begin
          state_s = IDLE;
        end else if (cnt_r == CW'(WIDTH - 1)) begin
          state_s = FINISH;
        end else begin
          state_s = RUN;
        end
      end
      FINISH:  state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // FSM outputs and HI/LO read port
  always_comb begin
    busy_s    = (state_r != IDLE);
    busy_o    = busy_s;
    done_o    = wr_fin_s;
    stall_o   = md_valid_i & (md_op_i != MD_NONE) & busy_s;
    mf_data_o = {WIDTH{1'b0}};
    if (md_valid_i) begin
      case (md_op_e'(md_op_i))
        MD_MFHI: mf_data_o = hi_r;
        MD_MFLO: mf_data_o = lo_r;
        default: mf_data_o = {WIDTH{1'b0}};
      endcase
    end else begin
      mf_data_o = {WIDTH{1'b0}};
    end
  end

  // Operand capture at start, then one step per RUN cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_r     <= {(2*WIDTH){1'b0}};
      b_r       <= {WIDTH{1'b0}};
      cnt_r     <= {CW{1'b0}};
      is_div_r  <= 1'b0;
      res_neg_r <= 1'b0;
      rem_neg_r <= 1'b0;
      div0_r    <= 1'b0;
    end else if (start_s) begin
      acc_r     <= {{WIDTH{1'b0}}, a_mag_s};
      b_r       <= b_mag_s;
      cnt_r     <= {CW{1'b0}};
      is_div_r  <= is_div_s;
      res_neg_r <= a_neg_s ^ b_neg_s;
      rem_neg_r <= a_neg_s;
      div0_r    <= is_div_s & (rt_i == {WIDTH{1'b0}});
    end else if (state_r == RUN) begin
      acc_r <= is_div_r ? div_next_s : mul_next_s;
      cnt_r <= cnt_r + CW'(1);
    end
  end

  // Architectural HI/LO: result write at FINISH, MTHI/MTLO only when idle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_r <= {WIDTH{1'b0}};
      lo_r <= {WIDTH{1'b0}};
    end else if (wr_fin_s) begin
      hi_r <= fin_hi_s;
      lo_r <= fin_lo_s;
    end else begin
      if (mt_hi_s) hi_r <= rs_i;
      if (mt_lo_s) lo_r <= rs_i;
    end
  end

  assign hi_o = hi_r;
  assign lo_o = lo_r;

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: stimulus pushes model results, a monitor checks each done_o.
module tb_ex_muldiv;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        md_valid;
  logic [3:0]  md_op;
  logic [31:0] rs, rt;
  logic        abort;
  logic        busy_o, stall_o, done_o;
  logic [31:0] hi_o, lo_o, mf_data_o;

  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] exp_q[$];
  logic        chk_pend = 1'b0;

  ex_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .md_valid_i(md_valid), .md_op_i(md_op),
    .rs_i(rs), .rt_i(rt), .abort_i(abort), .busy_o(busy_o), .stall_o(stall_o),
    .done_o(done_o), .hi_o(hi_o), .lo_o(lo_o), .mf_data_o(mf_data_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: {HI, LO} from plain 64-bit arithmetic
  function automatic logic [63:0] ref_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    res = 64'd0;
    case (op)
      MD_MULT:  res = sa * sb;
      MD_MULTU: res = {32'd0, a} * {32'd0, b};
      MD_DIV: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      MD_DIVU: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else res = {a % b, a / b};
      end
      default: res = 64'd0;
    endcase
    return res;
  endfunction

  // Monitor: one cycle after each done_o pulse, HI/LO must equal the oldest expectation
  always @(negedge clk) begin
    if (chk_pend) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done: got hilo %h expected no result", {hi_o, lo_o});
      end else begin
        check("hilo_result", {hi_o, lo_o}, exp_q.pop_front());
      end
    end
    chk_pend = done_o & ~reset;
  end

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input bit push);
    @(negedge clk);
    md_valid = 1'b1; md_op = op; rs = a; rt = b;
    #1;
    check("accept_no_stall", {63'd0, stall_o}, 64'd0);
    if (push) exp_q.push_back(ref_model(op, a, b));
    @(posedge clk); #1;
    md_valid = 1'b0; md_op = MD_NONE;
  endtask

  task automatic wait_idle(input string name);
    int cnt;
    int done_at;
    cnt = 0;
    done_at = 0;
    while (busy_o && cnt < 100) begin
      if (done_o) done_at = cnt + 1;
      @(posedge clk); #1;
      cnt++;
    end
    check(name, 64'(cnt), 64'd33);
    check("done_cycle", 64'(done_at), 64'd33);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    logic [3:0]  op;
    logic [31:0] a, b;
    logic [63:0] e;

    reset = 1'b1; md_valid = 1'b0; md_op = MD_NONE; rs = 32'd0; rt = 32'd0; abort = 1'b0;
    #12;
    check("reset_busy", {63'd0, busy_o}, 64'd0);
    check("reset_stall_done", {62'd0, stall_o, done_o}, 64'd0);
    check("reset_hilo", {hi_o, lo_o}, 64'd0);
    check("reset_mf", {32'd0, mf_data_o}, 64'd0);
    @(negedge clk); reset = 1'b0;

    issue(MD_MULT, 32'd7, 32'hFFFF_FFFD, 1'b1);
    wait_idle("mult_busy");
    check("mult_7_m3", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFEB);

    issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    wait_idle("multu_busy");
    check("multu_max", {hi_o, lo_o}, 64'hFFFF_FFFE_0000_0001);

    issue(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1);
    wait_idle("div_busy");
    check("div_m7_2", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFD);

    issue(MD_DIVU, 32'd100, 32'd0, 1'b1);
    wait_idle("divu0_busy");
    check("divu_by_zero", {hi_o, lo_o}, 64'h0000_0064_FFFF_FFFF);

    issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_idle("divovf_busy");
    check("div_overflow", {hi_o, lo_o}, 64'h0000_0000_8000_0000);

    // MFLO one cycle behind a MULT stalls until the product is written
    e = ref_model(MD_MULT, 32'h0001_2345, 32'hFFFF_FF00);
    issue(MD_MULT, 32'h0001_2345, 32'hFFFF_FF00, 1'b1);
    @(negedge clk); md_valid = 1'b1; md_op = MD_MFLO; #1;
    cnt = 0;
    while (stall_o && cnt < 100) begin @(posedge clk); #1; cnt++; end
    check("mflo_stall_len", 64'(cnt), 64'd33);
    check("mflo_data", {32'd0, mf_data_o}, {32'd0, e[31:0]});
    @(negedge clk); md_valid = 1'b0; md_op = MD_NONE;

    issue(MD_MTHI, 32'h1234_5678, 32'd0, 1'b0);
    check("mthi", {32'd0, hi_o}, 64'h0000_0000_1234_5678);

    // MTLO held while busy must not land until the unit is idle
    issue(MD_MULT, 32'd3, 32'd5, 1'b1);
    @(negedge clk); md_valid = 1'b1; md_op = MD_MTLO; rs = 32'hDEAD_BEEF; #1;
    check("mtlo_busy_stall", {63'd0, stall_o}, 64'd1);
    cnt = 0;
    while (stall_o && cnt < 100) begin @(posedge clk); #1; cnt++; end
    check("mtlo_stall_len", 64'(cnt), 64'd33);
    check("mtlo_lo_untouched", {32'd0, lo_o}, 64'd15);
    @(posedge clk); #1;
    check("mtlo_after_idle", {32'd0, lo_o}, 64'h0000_0000_DEAD_BEEF);
    md_valid = 1'b0; md_op = MD_NONE;

    issue(MD_MTHI, 32'h0BAD_F00D, 32'd0, 1'b0);
    issue(MD_MTLO, 32'h600D_CAFE, 32'd0, 1'b0);

    // Abort at RUN cycle 10: no result, HI/LO hold
    issue(MD_MULT, 32'h0000_1234, 32'h0000_5678, 1'b0);
    repeat (9) @(posedge clk);
    @(negedge clk); abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
    check("abort_busy", {63'd0, busy_o}, 64'd0);
    check("abort_hilo", {hi_o, lo_o}, 64'h0BAD_F00D_600D_CAFE);
    repeat (40) @(posedge clk);
    check("abort_no_late_done", {hi_o, lo_o}, 64'h0BAD_F00D_600D_CAFE);

    // Abort together with an IDLE request wins over both start and MT
    @(negedge clk); md_valid = 1'b1; md_op = MD_MTHI; rs = 32'h5555_AAAA; abort = 1'b1;
    @(posedge clk); #1;
    check("abort_idle_mt", {32'd0, hi_o}, 64'h0000_0000_0BAD_F00D);
    md_op = MD_DIV; rt = 32'd3;
    @(posedge clk); #1;
    check("abort_idle_start", {63'd0, busy_o}, 64'd0);
    md_valid = 1'b0; md_op = MD_NONE; abort = 1'b0;

    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(1, 4));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = 32'($urandom_range(0, 40)) - 32'd20; b = 32'($urandom_range(0, 10)) - 32'd5; end
        3: b = 32'($urandom_range(1, 9));
        default: ;
      endcase
      issue(op, a, b, 1'b1);
      wait_idle("rand_busy");
    end

    // Async reset mid-RUN clears everything without waiting for a clock edge
    issue(MD_DIVU, 32'hFFFF_0000, 32'd7, 1'b0);
    repeat (5) @(posedge clk);
    #2; reset = 1'b1; #1;
    check("rst_mid_busy", {62'd0, busy_o, done_o}, 64'd0);
    check("rst_mid_hilo", {hi_o, lo_o}, 64'd0);
    @(negedge clk); reset = 1'b0;

    repeat (3) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
